// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream beat in, downstream beat out,
// plus the hazard-unit stall/flush controls and an occupancy readout.
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // Upstream/hazard side: drives the beat and the stage controls.
    modport master (
        output in_valid, in_ctrl, in_data, stall, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    // The stage register itself.
    modport slave (
        input  in_valid, in_ctrl, in_data, stall, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall, flush and an
// optional skid entry so that in_ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 32,
    parameter bit SKID   = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    pipe_stage_reg_if.slave bus
);

    // Handshake: a beat moves on an edge where valid & ready are both high; valid
    // and its payload must hold until that edge, ready may change freely.
    // acc is the upstream transfer, deq the downstream one (stall masks it).
    logic              acc;
    logic              deq;
    logic              in_ready;

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;

    assign deq      = m_valid_q & bus.out_ready & ~bus.stall;
    // With a skid entry, readiness depends only on the skid flop, never on out_ready.
    assign in_ready = SKID ? ~s_valid_q : (~m_valid_q | deq);
    assign acc      = bus.in_valid & in_ready;

    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;

        if (bus.flush) begin
            // Payloads are kept; only validity and control are killed.
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (deq && s_valid_q) begin
            m_valid_d = 1'b1;
            m_ctrl_d  = s_ctrl_q;
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (deq || !m_valid_q) begin
            if (acc) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = bus.in_ctrl;
                m_data_d  = bus.in_data;
            end else begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end else if (acc && SKID) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = bus.in_ctrl;
            s_data_d  = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_ctrl_q  <= '0;
            m_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_ctrl_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_ctrl_q  <= m_ctrl_d;
            m_data_q  <= m_data_d;
            s_valid_q <= s_valid_d;
            s_ctrl_q  <= s_ctrl_d;
            s_data_q  <= s_data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = m_valid_q;
    assign bus.out_ctrl  = m_ctrl_q;
    assign bus.out_data  = m_data_q;
    assign bus.occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a SKID=1 instance for the handshake, flush, stall
// and reset scenarios, and a SKID=0 instance fed 100 random beats against a queue model.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic [39:0] exp_q[$];

  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) a_if ();
  pipe_stage_reg_if #(.CTRL_W(8), .DATA_W(32)) b_if ();

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1'b1)) dut_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (a_if.slave)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(32), .SKID(1'b0)) dut_noskid (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_a(input logic v, input logic [7:0] c, input logic [31:0] d);
    a_if.in_valid = v;
    a_if.in_ctrl  = c;
    a_if.in_data  = d;
  endtask

  initial begin
    int  sent;
    int  cyc;
    bit  ordy;
    bit  exp_rdy;

    rst_n = 1'b0;
    send_a(1'b0, 8'h00, 32'h0);
    a_if.stall = 1'b0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_ctrl = 8'h00; b_if.in_data = 32'h0;
    b_if.stall = 1'b0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", a_if.out_valid, 1'b0);
    check("rst_out_ctrl",  a_if.out_ctrl, 8'h00);
    check("rst_out_data",  a_if.out_data, 32'h0);
    check("rst_occupancy", a_if.occupancy, 2'd0);
    check("rst_in_ready",  a_if.in_ready, 1'b1);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", a_if.in_ready, 1'b1);

    // Streaming A1..A3 with out_ready=1
    a_if.out_ready = 1'b1;
    send_a(1'b1, 8'h11, 32'hA1);
    tick();
    check("a1_valid", a_if.out_valid, 1'b1);
    check("a1_data",  a_if.out_data, 32'hA1);
    check("a1_ctrl",  a_if.out_ctrl, 8'h11);
    check("a1_occ",   a_if.occupancy, 2'd1);
    send_a(1'b1, 8'h12, 32'hA2);
    tick();
    check("a2_data",  a_if.out_data, 32'hA2);
    check("a2_occ",   a_if.occupancy, 2'd1);
    send_a(1'b1, 8'h13, 32'hA3);
    tick();
    check("a3_data",  a_if.out_data, 32'hA3);
    check("a3_ctrl",  a_if.out_ctrl, 8'h13);
    check("a3_occ",   a_if.occupancy, 2'd1);
    send_a(1'b0, 8'h00, 32'h0);
    tick();
    check("drain_valid", a_if.out_valid, 1'b0);
    check("drain_ctrl",  a_if.out_ctrl, 8'h00);
    check("drain_data_held", a_if.out_data, 32'hA3);
    check("drain_occ",   a_if.occupancy, 2'd0);

    // Back-pressure fills the skid entry
    a_if.out_ready = 1'b0;
    send_a(1'b1, 8'h21, 32'hB1);
    tick();
    check("b1_data",  a_if.out_data, 32'hB1);
    check("b1_ready", a_if.in_ready, 1'b1);
    send_a(1'b1, 8'h22, 32'hB2);
    tick();
    check("b2_held_data", a_if.out_data, 32'hB1);
    check("b2_occ",   a_if.occupancy, 2'd2);
    check("b2_ready", a_if.in_ready, 1'b0);
    send_a(1'b1, 8'h2F, 32'hBF);
    tick();
    check("full_hold_data", a_if.out_data, 32'hB1);
    check("full_hold_occ",  a_if.occupancy, 2'd2);
    send_a(1'b0, 8'h00, 32'h0);
    a_if.out_ready = 1'b1;
    tick();
    check("b2_out_data",  a_if.out_data, 32'hB2);
    check("b2_out_ctrl",  a_if.out_ctrl, 8'h22);
    check("b2_out_ready", a_if.in_ready, 1'b1);
    check("b2_out_occ",   a_if.occupancy, 2'd1);
    tick();
    check("b_empty_valid", a_if.out_valid, 1'b0);
    check("b_empty_occ",   a_if.occupancy, 2'd0);

    // Flush with both entries full and an incoming beat
    a_if.out_ready = 1'b0;
    send_a(1'b1, 8'hFF, 32'hD1);
    tick();
    send_a(1'b1, 8'hFF, 32'hD2);
    tick();
    check("pre_flush_occ", a_if.occupancy, 2'd2);
    send_a(1'b1, 8'hFF, 32'hE0);
    a_if.flush = 1'b1;
    a_if.out_ready = 1'b1;
    tick();
    check("flush_valid", a_if.out_valid, 1'b0);
    check("flush_ctrl",  a_if.out_ctrl, 8'h00);
    check("flush_occ",   a_if.occupancy, 2'd0);
    check("flush_data_held", a_if.out_data, 32'hD1);
    check("flush_ready", a_if.in_ready, 1'b1);
    // Flush beats an acceptance into an empty stage, and a stall
    send_a(1'b1, 8'hFF, 32'hE1);
    a_if.stall = 1'b1;
    tick();
    check("flush_acc_valid", a_if.out_valid, 1'b0);
    check("flush_acc_ctrl",  a_if.out_ctrl, 8'h00);
    check("flush_acc_data",  a_if.out_data, 32'hD1);
    a_if.flush = 1'b0;
    a_if.stall = 1'b0;
    send_a(1'b0, 8'h00, 32'h0);
    tick();
    check("post_flush_valid", a_if.out_valid, 1'b0);

    // Stall holds M while a beat still lands in the skid entry
    a_if.out_ready = 1'b0;
    send_a(1'b1, 8'h31, 32'hC1);
    tick();
    a_if.out_ready = 1'b1;
    a_if.stall = 1'b1;
    send_a(1'b1, 8'h32, 32'hC2);
    tick();
    check("stall1_data", a_if.out_data, 32'hC1);
    check("stall1_occ",  a_if.occupancy, 2'd2);
    send_a(1'b0, 8'h00, 32'h0);
    for (int i = 2; i <= 3; i++) begin
      tick();
      check("stall_data",  a_if.out_data, 32'hC1);
      check("stall_valid", a_if.out_valid, 1'b1);
    end
    a_if.stall = 1'b0;
    tick();
    check("unstall_data", a_if.out_data, 32'hC2);
    check("unstall_occ",  a_if.occupancy, 2'd1);
    tick();
    check("unstall_empty", a_if.out_valid, 1'b0);

    // Asynchronous reset mid-cycle with both entries full
    a_if.out_ready = 1'b0;
    send_a(1'b1, 8'h41, 32'hF1);
    tick();
    send_a(1'b1, 8'h42, 32'hF2);
    tick();
    check("pre_rst_occ", a_if.occupancy, 2'd2);
    send_a(1'b0, 8'h00, 32'h0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", a_if.out_valid, 1'b0);
    check("arst_ctrl",  a_if.out_ctrl, 8'h00);
    check("arst_data",  a_if.out_data, 32'h0);
    check("arst_occ",   a_if.occupancy, 2'd0);
    check("arst_ready", a_if.in_ready, 1'b1);
    #1 rst_n = 1'b1;
    tick();
    check("arst_after_occ", a_if.occupancy, 2'd0);

    // SKID=0: toggling out_ready, 100 random beats against the queue model
    sent = 0;
    cyc  = 0;
    ordy = 1'b0;
    while ((sent < 100 || exp_q.size() != 0) && cyc < 2000) begin
      ordy = ~ordy;
      b_if.out_ready = ordy;
      if (sent < 100) begin
        b_if.in_valid = 1'($urandom_range(0, 1));
        b_if.in_ctrl  = 8'($urandom_range(1, 255));
        b_if.in_data  = $urandom;
      end else begin
        b_if.in_valid = 1'b0;
      end
      #1;
      exp_rdy = (exp_q.size() == 0) || ordy;
      check("s0_in_ready", b_if.in_ready, exp_rdy);
      check("s0_occ", b_if.occupancy, 40'(exp_q.size()));
      if (exp_q.size() != 0) begin
        check("s0_valid", b_if.out_valid, 1'b1);
        if (ordy) begin
          check("s0_beat", {b_if.out_ctrl, b_if.out_data}, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end else begin
        check("s0_bubble_valid", b_if.out_valid, 1'b0);
        check("s0_bubble_ctrl",  b_if.out_ctrl, 8'h00);
      end
      if (b_if.in_valid && exp_rdy) begin
        exp_q.push_back({b_if.in_ctrl, b_if.in_data});
        sent++;
      end
      tick();
      cyc++;
    end
    check("s0_timeout", 1'(cyc < 2000), 1'b1);
    check("s0_sent", sent, 100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
